risc_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 32-bit RISC core (IF, DOF, EX, WB stages, 10-bit PC, 32 x 32-bit register file).
- Detects read-after-write hazards between the DOF-stage source registers and the EX/WB destination registers, and generates stall and bubble controls.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Sequences post-reset pipeline warm-up and debug halt/drain.
- Keeps saturating stall and flush event counters.
- Sits beside the datapath in RISC_Top and drives the PC, IF/DOF and DOF/EX register enables.

---
 rtl/risc_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_risc_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/risc_hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage RISC core: RAW stall detection,
// taken-branch squash, post-reset warm-up, debug halt/drain and event counters.
module risc_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       A_DOF,
  input  logic [4:0]       B_DOF,
  input  logic             ra_used,
  input  logic             rb_used,
  input  logic             rw_ex,
  input  logic [4:0]       da_ex,
  input  logic             RW_WB,
  input  logic [4:0]       DA_WB,
  input  logic             br_taken_ex,
  input  logic             halt_req,
  output logic             pc_hold,
  output logic             dof_bubble,
  output logic             if_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           state_r;
  logic [IW-1:0]    init_cnt_r;
  logic [1:0]       drain_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             hz_s;
  logic             stall_ev_s;
  logic             flush_ev_s;

  // R0 is hardwired, and the register file has no write-through, so WB matches stall too.
  function automatic logic src_hazard(input logic used, input logic [4:0] src,
                                      input logic ex_wr, input logic [4:0] ex_dst,
                                      input logic wb_wr, input logic [4:0] wb_dst);
    return used & (src != 5'd0) &
           ((ex_wr & (ex_dst == src)) | (wb_wr & (wb_dst == src)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Mealy stage controls and event strobes from current state and same-cycle inputs.
  always_comb begin
    hz_s = src_hazard(ra_used, A_DOF, rw_ex, da_ex, RW_WB, DA_WB) |
           src_hazard(rb_used, B_DOF, rw_ex, da_ex, RW_WB, DA_WB);
    pc_hold    = 1'b1;
    dof_bubble = 1'b1;
    if_flush   = 1'b1;
    stall_ev_s = 1'b0;
    flush_ev_s = 1'b0;
    if (reset) begin
      pc_hold    = 1'b1;
      dof_bubble = 1'b1;
      if_flush   = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          pc_hold    = 1'b1;
          dof_bubble = 1'b1;
          if_flush   = 1'b1;
        end
        ST_RUN: begin
          if (br_taken_ex) begin
            pc_hold    = 1'b0;
            dof_bubble = 1'b1;
            if_flush   = 1'b1;
            flush_ev_s = 1'b1;
          end else if (hz_s) begin
            pc_hold    = 1'b1;
            dof_bubble = 1'b1;
            if_flush   = 1'b0;
            stall_ev_s = 1'b1;
          end else begin
            pc_hold    = 1'b0;
            dof_bubble = 1'b0;
            if_flush   = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (br_taken_ex) begin
            pc_hold    = 1'b0;
            dof_bubble = 1'b1;
            if_flush   = 1'b1;
            flush_ev_s = 1'b1;
          end else begin
            pc_hold    = 1'b1;
            dof_bubble = 1'b1;
            if_flush   = 1'b0;
          end
        end
        ST_HALTED: begin
          pc_hold    = 1'b1;
          dof_bubble = 1'b1;
          if_flush   = 1'b0;
        end
        default: begin
          pc_hold    = 1'b1;
          dof_bubble = 1'b1;
          if_flush   = 1'b1;
        end
      endcase
    end
  end

  // Sequencing FSM, warm-up/drain counters and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {IW{1'b0}};
      drain_cnt_r <= 2'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_ev_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == INIT_LAST) begin
            state_r <= ST_RUN;
          end else begin
            init_cnt_r <= init_cnt_r + IW'(1);
          end
        end
        ST_RUN: begin
          if (halt_req && !br_taken_ex && !hz_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= 2'd2;
          end
        end
        ST_DRAIN: begin
          // A taken branch refills the front end, so the drain restarts.
          if (br_taken_ex) begin
            drain_cnt_r <= 2'd2;
          end else if (drain_cnt_r == 2'd1) begin
            drain_cnt_r <= 2'd0;
            state_r     <= ST_HALTED;
          end else begin
            drain_cnt_r <= drain_cnt_r - 2'd1;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign halted    = (state_r == ST_HALTED);
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_risc_hazard_ctrl.sv
// Self-checking bench for risc_hazard_ctrl: directed vector table, saturation
// sequence, then random stimulus against a cycles-remaining reference model.
module tb_risc_hazard_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] A_DOF, B_DOF, da_ex, DA_WB;
  logic ra_used, rb_used, rw_ex, RW_WB, br_taken_ex, halt_req;
  logic pc_hold, dof_bubble, if_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  risc_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .A_DOF(A_DOF), .B_DOF(B_DOF),
    .ra_used(ra_used), .rb_used(rb_used), .rw_ex(rw_ex), .da_ex(da_ex),
    .RW_WB(RW_WB), .DA_WB(DA_WB), .br_taken_ex(br_taken_ex), .halt_req(halt_req),
    .pc_hold(pc_hold), .dof_bubble(dof_bubble), .if_flush(if_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic ra; logic [4:0] a;
    logic rb; logic [4:0] b;
    logic rwex; logic [4:0] daex;
    logic rwwb; logic [4:0] dawb;
    logic br; logic halt;
    logic [3:0] exp_ctl;   // {pc_hold, dof_bubble, if_flush, halted}
    int exp_st; int exp_fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input int rst, input int ra, input int a, input int rb, input int b,
                               input int rwex, input int daex, input int rwwb, input int dawb,
                               input int br, input int halt, input logic [3:0] ctl,
                               input int st, input int fl);
    vec_t v;
    v.rst = rst[0]; v.ra = ra[0]; v.a = a[4:0]; v.rb = rb[0]; v.b = b[4:0];
    v.rwex = rwex[0]; v.daex = daex[4:0]; v.rwwb = rwwb[0]; v.dawb = dawb[4:0];
    v.br = br[0]; v.halt = halt[0]; v.exp_ctl = ctl; v.exp_st = st; v.exp_fl = fl;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; ra_used = v.ra; A_DOF = v.a; rb_used = v.rb; B_DOF = v.b;
    rw_ex = v.rwex; da_ex = v.daex; RW_WB = v.rwwb; DA_WB = v.dawb;
    br_taken_ex = v.br; halt_req = v.halt;
  endtask

  // Reference model: remaining warm-up cycles, remaining drain cycles, halted flag.
  int m_init_left, m_drain_left, m_st, m_fl;
  bit m_halted;

  function automatic bit model_hz();
    logic [4:0] src [2];
    bit used [2];
    bit r = 1'b0;
    src[0] = A_DOF; src[1] = B_DOF; used[0] = ra_used; used[1] = rb_used;
    for (int s = 0; s < 2; s++)
      if (used[s] && src[s] != 0 && ((rw_ex && da_ex == src[s]) || (RW_WB && DA_WB == src[s])))
        r = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] model_ctl();
    logic [2:0] c;
    if (reset || m_init_left > 0) c = 3'b111;
    else if (m_halted) c = 3'b110;
    else if (m_drain_left > 0) c = br_taken_ex ? 3'b011 : 3'b110;
    else if (br_taken_ex) c = 3'b011;
    else if (model_hz()) c = 3'b110;
    else c = 3'b000;
    return {c, m_halted};
  endfunction

  task automatic model_reset();
    m_init_left = INIT_CYCLES; m_drain_left = 0; m_halted = 1'b0; m_st = 0; m_fl = 0;
  endtask

  task automatic model_step();
    if (reset) model_reset();
    else if (m_init_left > 0) m_init_left--;
    else if (m_halted) begin
      if (!halt_req) m_halted = 1'b0;
    end else if (m_drain_left > 0) begin
      if (br_taken_ex) begin
        m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
        m_drain_left = 2;
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1'b1;
      end
    end else if (br_taken_ex) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
    else if (model_hz()) m_st = (m_st < CMAX) ? m_st + 1 : CMAX;
    else if (halt_req) m_drain_left = 2;
  endtask

  initial begin
    apply(mkv(1, 0,0, 0,0, 0,0, 0,0, 0,0, 4'b1110, 0, 0));
    @(posedge clk); #1;

    //           rst ra a  rb b  rwex da rwwb dw br hlt  ctl      st fl
    tbl.push_back(mkv(1, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 0, 0));  // reset cycle
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 0, 0));  // INIT 1
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 0, 0));  // INIT 2
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 0, 0));  // first RUN
    tbl.push_back(mkv(0, 1,5, 0,0, 1,5, 0,0,  0,0, 4'b1100, 0, 0));  // EX hazard
    tbl.push_back(mkv(0, 1,5, 0,0, 0,0, 1,5,  0,0, 4'b1100, 1, 0));  // WB hazard
    tbl.push_back(mkv(0, 1,5, 0,0, 0,0, 0,0,  0,0, 4'b0000, 2, 0));
    tbl.push_back(mkv(0, 1,0, 0,0, 1,0, 0,0,  0,0, 4'b0000, 2, 0));  // R0
    tbl.push_back(mkv(0, 0,0, 0,7, 1,7, 0,0,  0,0, 4'b0000, 2, 0));  // rb unused
    tbl.push_back(mkv(0, 1,3, 0,0, 0,3, 0,3,  0,0, 4'b0000, 2, 0));  // no writers
    tbl.push_back(mkv(0, 0,0, 1,9, 0,0, 1,9,  0,0, 4'b1100, 2, 0));  // B via WB
    tbl.push_back(mkv(0, 1,5, 0,0, 1,5, 0,0,  1,0, 4'b0110, 3, 0));  // branch beats hz
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 3, 1));
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b0000, 3, 1));  // halt sampled
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1100, 3, 1));  // DRAIN 1, req dropped
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b1100, 3, 1));  // DRAIN 2
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b1101, 3, 1));  // HALTED
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1101, 3, 1));  // resume
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 3, 1));
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b0000, 3, 1));  // halt sampled
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  1,1, 4'b0110, 3, 1));  // branch in DRAIN 1
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b1100, 3, 2));  // DRAIN 2
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,1, 4'b1100, 3, 2));  // DRAIN 3
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1101, 3, 2));  // HALTED, resume
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 3, 2));
    tbl.push_back(mkv(0, 1,4, 0,0, 1,4, 0,0,  0,1, 4'b1100, 3, 2));  // halt blocked by hz
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 4, 2));
    tbl.push_back(mkv(1, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 4, 2));  // reset in RUN
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 0, 0));
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b1110, 0, 0));
    tbl.push_back(mkv(0, 0,0, 0,0, 0,0, 0,0,  0,0, 4'b0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d {ctl,st,fl}", i),
            {20'd0, pc_hold, dof_bubble, if_flush, halted, stall_cnt, flush_cnt},
            {20'd0, tbl[i].exp_ctl, 4'(tbl[i].exp_st), 4'(tbl[i].exp_fl)});
      @(posedge clk); #1;
    end

    // 20 back-to-back EX hazards: stall_cnt saturates at 15.
    for (int i = 0; i < 20; i++) begin
      apply(mkv(0, 1,6, 0,0, 1,6, 0,0, 0,0, 4'b0, 0, 0));
      @(negedge clk);
      check($sformatf("sat%0d {ctl,st}", i), {24'd0, pc_hold, dof_bubble, if_flush, halted, stall_cnt},
            {24'd0, 4'b1100, 4'((i < CMAX) ? i : CMAX)});
      @(posedge clk); #1;
    end
    apply(mkv(0, 0,0, 0,0, 0,0, 0,0, 0,0, 4'b0, 0, 0));
    @(negedge clk);
    check("sat_hold", {24'd0, pc_hold, dof_bubble, if_flush, halted, stall_cnt}, {24'd0, 4'b0000, 4'(CMAX)});
    @(posedge clk); #1;

    // Random phase against the reference model.
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      ra_used = $urandom_range(0, 1); rb_used = $urandom_range(0, 1);
      A_DOF = 5'($urandom_range(0, 3)); B_DOF = 5'($urandom_range(0, 3));
      rw_ex = $urandom_range(0, 1); da_ex = 5'($urandom_range(0, 3));
      RW_WB = $urandom_range(0, 1); DA_WB = 5'($urandom_range(0, 3));
      br_taken_ex = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      @(negedge clk);
      check($sformatf("rnd%0d {ctl,st,fl}", n),
            {20'd0, pc_hold, dof_bubble, if_flush, halted, stall_cnt, flush_cnt},
            {20'd0, model_ctl(), 4'(m_st), 4'(m_fl)});
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
